// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg: ISA opcodes, opcode field location and dispatch targets shared by controller and dispatcher
package gpu_isa_pkg;
  typedef enum logic [3:0] {
    OP_NOP       = 4'b0000,
    OP_ADDI      = 4'b0001,
    OP_SUBI      = 4'b0010,
    OP_BGE       = 4'b0011,
    OP_BLT       = 4'b0100,
    OP_JUMP      = 4'b0101,
    OP_SMA       = 4'b0110,
    OP_LOADI     = 4'b0111,
    OP_SENDL     = 4'b1000,
    OP_LOADB     = 4'b1001,
    OP_LOAD      = 4'b1010,
    OP_WRITEB    = 4'b1011,
    OP_WRITE     = 4'b1100,
    OP_OR        = 4'b1101,
    OP_SENDITERS = 4'b1110,
    OP_HALT      = 4'b1111
  } opcode_t;
  // Opcode occupies the first four bits of an ascending [0:W-1] instruction word
  localparam int OPCODE_FIRST = 0;
  localparam int OPCODE_LAST  = 3;
  typedef enum logic {
    TGT_MEM = 1'b0,
    TGT_FB  = 1'b1
  } target_t;
  // Everything from SMA up to SENDITERS leaves the controller; the rest stays local
  function automatic logic is_routed(opcode_t op);
    return (op >= OP_SMA) && (op != OP_HALT);
  endfunction
  function automatic target_t target_of(opcode_t op);
    return (op == OP_SENDITERS) ? TGT_FB : TGT_MEM;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous in-order queue with wrap-around pointers and occupancy count
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  // Storage needs no reset: reads are only meaningful while count is nonzero
  always_ff @(posedge clk_in)
    if (do_push) mem[wr_ptr] <= din;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_in)
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_dispatcher.sv
// instr_dispatcher: routes controller instructions to memory / frame-buffer channels in program order (optional INSTR_DISPATCH_STALL_COUNT_EN adds stall_cycles_out)
module instr_dispatcher
  import gpu_isa_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PRIVATE_REG_WIDTH = 16,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1] instr_in,
  input  logic [PRIVATE_REG_WIDTH-1:0] reg_a_in,
  input  logic [PRIVATE_REG_WIDTH-1:0] reg_b_in,
  input  logic [PRIVATE_REG_WIDTH-1:0] reg_c_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  output logic [0:INSTRUCTION_WIDTH-1] mem_instr_out,
  output logic [PRIVATE_REG_WIDTH-1:0] mem_reg_a_out,
  output logic [PRIVATE_REG_WIDTH-1:0] mem_reg_b_out,
  output logic [PRIVATE_REG_WIDTH-1:0] mem_reg_c_out,
  output logic                         mem_valid_out,
  input  logic                         mem_ready_in,
  output logic [0:INSTRUCTION_WIDTH-1] fb_instr_out,
  output logic [PRIVATE_REG_WIDTH-1:0] fb_reg_a_out,
  output logic                         fb_valid_out,
  input  logic                         fb_ready_in,
  output logic                         idle_out
`ifdef INSTR_DISPATCH_STALL_COUNT_EN
  ,
  output logic [31:0]                  stall_cycles_out
`endif
);
  localparam int RW = PRIVATE_REG_WIDTH;
  localparam int EW = 1 + INSTRUCTION_WIDTH + 3 * RW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  opcode_t opcode;
  target_t head_tgt;
  logic [EW-1:0] din, head;
  logic [CW-1:0] count;
  logic full, empty, push, pop;
  assign opcode          = opcode_t'(instr_in[OPCODE_FIRST:OPCODE_LAST]);
  assign instr_ready_out = !full;
  assign push            = instr_valid_in && !full && is_routed(opcode);
  assign din             = {target_of(opcode), instr_in, reg_a_in, reg_b_in, reg_c_in};
  assign head_tgt        = target_t'(head[EW-1]);
  assign mem_valid_out   = !empty && head_tgt == TGT_MEM;
  assign fb_valid_out    = !empty && head_tgt == TGT_FB;
  assign pop             = (mem_valid_out && mem_ready_in) || (fb_valid_out && fb_ready_in);
  assign idle_out        = count == '0;
  instr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // Only the head is ever exposed; payloads are forced to zero on an idle channel
  always_comb begin
    mem_instr_out = mem_valid_out ? head[EW-2 -: INSTRUCTION_WIDTH] : '0;
    mem_reg_a_out = mem_valid_out ? head[3*RW-1 -: RW] : '0;
    mem_reg_b_out = mem_valid_out ? head[2*RW-1 -: RW] : '0;
    mem_reg_c_out = mem_valid_out ? head[RW-1:0] : '0;
    fb_instr_out  = fb_valid_out ? head[EW-2 -: INSTRUCTION_WIDTH] : '0;
    fb_reg_a_out  = fb_valid_out ? head[3*RW-1 -: RW] : '0;
  end
`ifdef INSTR_DISPATCH_STALL_COUNT_EN
  // Counts cycles the controller is held off by a full queue, saturating
  always_ff @(posedge clk_in)
    if (rst_in) stall_cycles_out <= '0;
    else if (instr_valid_in && full && stall_cycles_out != 32'hFFFF_FFFF) stall_cycles_out <= stall_cycles_out + 1'b1;
`endif
endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher: directed and scoreboarded checks of instr_dispatcher
module tb_instr_dispatcher;
  logic clk_in = 0;
  logic rst_in = 1;
  logic [0:31] instr_in = '0;
  logic [15:0] reg_a_in = '0, reg_b_in = '0, reg_c_in = '0;
  logic instr_valid_in = 0, instr_ready_out;
  logic [0:31] mem_instr_out, fb_instr_out;
  logic [15:0] mem_reg_a_out, mem_reg_b_out, mem_reg_c_out, fb_reg_a_out;
  logic mem_valid_out, mem_ready_in = 0, fb_valid_out, fb_ready_in = 0, idle_out;
`ifdef INSTR_DISPATCH_STALL_COUNT_EN
  logic [31:0] stall_cycles_out;
`endif
  int tests = 0, fails = 0;
  always #5 clk_in = ~clk_in;
  instr_dispatcher dut (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr_in),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .reg_c_in(reg_c_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .mem_instr_out(mem_instr_out), .mem_reg_a_out(mem_reg_a_out),
    .mem_reg_b_out(mem_reg_b_out), .mem_reg_c_out(mem_reg_c_out),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
    .fb_instr_out(fb_instr_out), .fb_reg_a_out(fb_reg_a_out),
    .fb_valid_out(fb_valid_out), .fb_ready_in(fb_ready_in),
    .idle_out(idle_out)
`ifdef INSTR_DISPATCH_STALL_COUNT_EN
    , .stall_cycles_out(stall_cycles_out)
`endif
  );

  task automatic test_reset;
    rst_in = 1; instr_valid_in = 0; mem_ready_in = 0; fb_ready_in = 0;
    repeat (2) @(negedge clk_in);
    rst_in = 0;
    #1;
    tests++; if (mem_valid_out !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid_out); end
    tests++; if (fb_valid_out !== 1'b0) begin fails++; $display("FAIL reset_fb_valid got %b exp 0", fb_valid_out); end
    tests++; if (instr_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", instr_ready_out); end
    tests++; if (idle_out !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", idle_out); end
    tests++; if (mem_instr_out !== 32'h0) begin fails++; $display("FAIL reset_mem_instr got %h exp 0", mem_instr_out); end
`ifdef INSTR_DISPATCH_STALL_COUNT_EN
    tests++; if (stall_cycles_out !== 32'h0) begin fails++; $display("FAIL reset_stall got %0d exp 0", stall_cycles_out); end
`endif
  endtask

  task automatic test_loadi;
    @(negedge clk_in);
    mem_ready_in = 1; instr_valid_in = 1; instr_in = 32'h7123_4567;
    reg_a_in = 16'h1111; reg_b_in = 16'h2222; reg_c_in = 16'h3333;
    #1;
    tests++; if (instr_ready_out !== 1'b1) begin fails++; $display("FAIL loadi_ready got %b exp 1", instr_ready_out); end
    @(negedge clk_in);
    instr_valid_in = 0;
    #1;
    tests++; if (mem_valid_out !== 1'b1) begin fails++; $display("FAIL loadi_mem_valid got %b exp 1", mem_valid_out); end
    tests++; if (mem_instr_out !== 32'h7123_4567) begin fails++; $display("FAIL loadi_instr got %h exp 71234567", mem_instr_out); end
    tests++; if ({mem_reg_a_out, mem_reg_b_out, mem_reg_c_out} !== 48'h1111_2222_3333) begin fails++; $display("FAIL loadi_regs got %h %h %h exp 1111 2222 3333", mem_reg_a_out, mem_reg_b_out, mem_reg_c_out); end
    tests++; if (fb_valid_out !== 1'b0 || idle_out !== 1'b0) begin fails++; $display("FAIL loadi_fb_idle got fb=%b idle=%b exp 0 0", fb_valid_out, idle_out); end
    @(negedge clk_in);
    #1;
    tests++; if (mem_valid_out !== 1'b0 || mem_instr_out !== 32'h0) begin fails++; $display("FAIL loadi_popped got v=%b i=%h exp 0 0", mem_valid_out, mem_instr_out); end
    tests++; if (idle_out !== 1'b1) begin fails++; $display("FAIL loadi_idle got %b exp 1", idle_out); end
  endtask

  task automatic test_discard;
    logic [3:0] ops [4] = '{4'h1, 4'h3, 4'h5, 4'h0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      instr_valid_in = 1; instr_in = {ops[i], 28'h00000AB};
      #1;
      tests++; if (instr_ready_out !== 1'b1) begin fails++; $display("FAIL discard_ready op=%h got %b exp 1", ops[i], instr_ready_out); end
      @(negedge clk_in);
      instr_valid_in = 0;
      #1;
      tests++; if (mem_valid_out !== 1'b0 || fb_valid_out !== 1'b0 || idle_out !== 1'b1) begin fails++; $display("FAIL discard op=%h got mv=%b fv=%b idle=%b exp 0 0 1", ops[i], mem_valid_out, fb_valid_out, idle_out); end
    end
  endtask

  task automatic test_full_stall;
    mem_ready_in = 0; fb_ready_in = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      instr_valid_in = 1; instr_in = 32'h6000_0000 + i;
      #1;
      tests++; if (instr_ready_out !== (i < 4)) begin fails++; $display("FAIL full_ready i=%0d got %b exp %b", i, instr_ready_out, i < 4); end
    end
    repeat (3) @(negedge clk_in);
    instr_valid_in = 0;
    #1;
`ifdef INSTR_DISPATCH_STALL_COUNT_EN
    tests++; if (stall_cycles_out !== 32'd3) begin fails++; $display("FAIL stall_count got %0d exp 3", stall_cycles_out); end
`endif
    tests++; if (mem_valid_out !== 1'b1 || mem_instr_out !== 32'h6000_0000) begin fails++; $display("FAIL full_hold got v=%b i=%h exp 1 60000000", mem_valid_out, mem_instr_out); end
    mem_ready_in = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (mem_valid_out !== 1'b1 || mem_instr_out !== 32'h6000_0000 + k) begin fails++; $display("FAIL full_drain k=%0d got v=%b i=%h exp 1 %h", k, mem_valid_out, mem_instr_out, 32'h6000_0000 + k); end
      @(negedge clk_in);
    end
    #1;
    tests++; if (idle_out !== 1'b1 || mem_valid_out !== 1'b0) begin fails++; $display("FAIL full_empty got idle=%b v=%b exp 1 0", idle_out, mem_valid_out); end
  endtask

  task automatic test_order;
    mem_ready_in = 0; fb_ready_in = 1;
    @(negedge clk_in);
    instr_valid_in = 1; instr_in = 32'h8000_00AA; reg_a_in = 16'h00AA;
    @(negedge clk_in);
    instr_in = 32'hE000_00BB; reg_a_in = 16'h00BB;
    @(negedge clk_in);
    instr_valid_in = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (fb_valid_out !== 1'b0 || mem_instr_out !== 32'h8000_00AA) begin fails++; $display("FAIL order_block k=%0d got fv=%b mi=%h exp 0 800000aa", k, fb_valid_out, mem_instr_out); end
      @(negedge clk_in);
    end
    mem_ready_in = 1;
    @(negedge clk_in);
    #1;
    tests++; if (fb_valid_out !== 1'b1 || mem_valid_out !== 1'b0) begin fails++; $display("FAIL order_fb_valid got fv=%b mv=%b exp 1 0", fb_valid_out, mem_valid_out); end
    tests++; if (fb_instr_out !== 32'hE000_00BB || fb_reg_a_out !== 16'h00BB) begin fails++; $display("FAIL order_fb_payload got %h %h exp e00000bb 00bb", fb_instr_out, fb_reg_a_out); end
    @(negedge clk_in);
    #1;
    tests++; if (idle_out !== 1'b1 || fb_valid_out !== 1'b0) begin fails++; $display("FAIL order_done got idle=%b fv=%b exp 1 0", idle_out, fb_valid_out); end
  endtask

  task automatic test_reset_mid;
    mem_ready_in = 0; fb_ready_in = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_in);
      instr_valid_in = 1; instr_in = 32'h7000_0000 + i;
    end
    @(negedge clk_in);
    rst_in = 1; instr_in = 32'h7000_00FF;
    @(negedge clk_in);
    rst_in = 0; instr_valid_in = 0;
    #1;
    tests++; if (mem_valid_out !== 1'b0 || fb_valid_out !== 1'b0 || idle_out !== 1'b1 || instr_ready_out !== 1'b1) begin fails++; $display("FAIL midreset got mv=%b fv=%b idle=%b rdy=%b exp 0 0 1 1", mem_valid_out, fb_valid_out, idle_out, instr_ready_out); end
    mem_ready_in = 1; fb_ready_in = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      #1;
      tests++; if (mem_valid_out !== 1'b0 || idle_out !== 1'b1) begin fails++; $display("FAIL midreset_stale k=%0d got mv=%b idle=%b exp 0 1", k, mem_valid_out, idle_out); end
    end
  endtask

  task automatic test_back_to_back;
    mem_ready_in = 0; fb_ready_in = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_in);
      instr_valid_in = 1; instr_in = 32'h9000_0000 + i;
    end
    @(negedge clk_in);
    instr_in = 32'h9000_0005; mem_ready_in = 1;
    #1;
    tests++; if (instr_ready_out !== 1'b0 || mem_instr_out !== 32'h9000_0001) begin fails++; $display("FAIL b2b_full got rdy=%b i=%h exp 0 90000001", instr_ready_out, mem_instr_out); end
    @(negedge clk_in);
    #1;
    tests++; if (instr_ready_out !== 1'b1 || mem_instr_out !== 32'h9000_0002) begin fails++; $display("FAIL b2b_pop got rdy=%b i=%h exp 1 90000002", instr_ready_out, mem_instr_out); end
    @(negedge clk_in);
    instr_valid_in = 0;
    for (int k = 3; k <= 5; k++) begin
      #1;
      tests++; if (mem_valid_out !== 1'b1 || mem_instr_out !== 32'h9000_0000 + k) begin fails++; $display("FAIL b2b_order k=%0d got v=%b i=%h exp 1 %h", k, mem_valid_out, mem_instr_out, 32'h9000_0000 + k); end
      @(negedge clk_in);
    end
    #1;
    tests++; if (idle_out !== 1'b1) begin fails++; $display("FAIL b2b_idle got %b exp 1", idle_out); end
  endtask

  task automatic test_random;
    logic [31:0] sb [$];
    logic [31:0] w;
    logic v, mr, fr, emv, efv, rtd;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk_in);
      if (k < 20) begin
        v = 1'($urandom_range(0, 1)); w = {4'($urandom_range(0, 15)), 28'($urandom)};
        mr = 1'($urandom_range(0, 1)); fr = 1'($urandom_range(0, 1));
      end else begin
        v = 0; mr = 1; fr = 1;
      end
      instr_valid_in = v; instr_in = w; reg_a_in = w[15:0]; mem_ready_in = mr; fb_ready_in = fr;
      #1;
      emv = sb.size() > 0 && sb[0][31:28] != 4'hE;
      efv = sb.size() > 0 && sb[0][31:28] == 4'hE;
      tests++; if (mem_valid_out !== emv || fb_valid_out !== efv) begin fails++; $display("FAIL rand_valid k=%0d got mv=%b fv=%b exp %b %b", k, mem_valid_out, fb_valid_out, emv, efv); end
      tests++; if (instr_ready_out !== (sb.size() < 4)) begin fails++; $display("FAIL rand_ready k=%0d got %b exp %b", k, instr_ready_out, sb.size() < 4); end
      if (emv) begin
        tests++; if (mem_instr_out !== sb[0]) begin fails++; $display("FAIL rand_mem k=%0d got %h exp %h", k, mem_instr_out, sb[0]); end
      end
      if (efv) begin
        tests++; if (fb_instr_out !== sb[0] || fb_reg_a_out !== sb[0][15:0]) begin fails++; $display("FAIL rand_fb k=%0d got %h %h exp %h", k, fb_instr_out, fb_reg_a_out, sb[0]); end
      end
      rtd = w[31:28] >= 4'h6 && w[31:28] != 4'hF;
      if (v && rtd && sb.size() < 4) begin
        if ((emv && mr) || (efv && fr)) void'(sb.pop_front());
        sb.push_back(w);
      end else if ((emv && mr) || (efv && fr)) void'(sb.pop_front());
    end
    @(negedge clk_in);
    #1;
    tests++; if (idle_out !== (sb.size() == 0)) begin fails++; $display("FAIL rand_idle got %b exp %b", idle_out, sb.size() == 0); end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_discard();
    test_full_stall();
    test_order();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
